// File: rtl/multiplexer.sv
// multiplexer: clocked WIDTH-bit 2:1 selector choosing functional or BIST data for the RAM path
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset, clears result and select_q
//   one          word captured when select = 0
//   two          word captured when select = 1
//   select       source select
//   result       registered selected word, one clock behind the inputs
//   select_q     registered select, tags which source result came from
//   switch_count 16-bit saturating count of registered source switches,
//                present only when MULTIPLEXER_SWITCH_COUNT_EN is defined
module multiplexer #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] one,
    input  logic [WIDTH-1:0] two,
    input  logic             select,
    output logic [WIDTH-1:0] result,
    output logic             select_q
`ifdef MULTIPLEXER_SWITCH_COUNT_EN
    ,
    output logic [15:0]      switch_count
`endif
);
    // An X on select propagates into result so bad stimulus stays visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            result   <= '0;
            select_q <= 1'b0;
        end else begin
            result   <= select ? two : one;
            select_q <= select;
        end
    end
`ifdef MULTIPLEXER_SWITCH_COUNT_EN
    // A switch is a new select differing from the one already registered; saturates.
    always_ff @(posedge clk) begin
        if (rst)
            switch_count <= '0;
        else if (select != select_q && switch_count != 16'hFFFF)
            switch_count <= switch_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_multiplexer.sv
// tb_multiplexer: scoreboard-based self-checking bench for multiplexer
module tb_multiplexer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [8:0] one = '0;
    logic [8:0] two = '0;
    logic       select = 1'b0;
    logic [8:0] result;
    logic       select_q;
`ifdef MULTIPLEXER_SWITCH_COUNT_EN
    logic [15:0] switch_count;
`endif

    multiplexer #(.WIDTH(9)) dut (
        .clk(clk),
        .rst(rst),
        .one(one),
        .two(two),
        .select(select),
        .result(result),
        .select_q(select_q)
`ifdef MULTIPLEXER_SWITCH_COUNT_EN
        ,
        .switch_count(switch_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0]  res;
        logic        sq;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic        m_sq = 1'b0;
    logic [15:0] m_cnt = 16'd0;
    int          errors = 0;
    int          checks = 0;

    initial begin
        #5ms;
        $display("FAIL timeout: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    // Applies inputs at the falling edge and records what the next rising edge must produce.
    task automatic drive(input logic r, input logic s, input logic [8:0] a, input logic [8:0] b);
        exp_t x;
        @(negedge clk);
        rst = r; select = s; one = a; two = b;
        x.res = r ? 9'h000 : (s ? b : a);
        x.sq  = r ? 1'b0 : s;
        m_cnt = r ? 16'd0 : ((s != m_sq && m_cnt != 16'hFFFF) ? m_cnt + 16'd1 : m_cnt);
        m_sq  = x.sq;
        x.cnt = m_cnt;
        sb.push_back(x);
    endtask

    task automatic wait_out();
        @(posedge clk);
        #1;
        e = sb.pop_front();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 9'h1FF, 9'h100);
            wait_out();
            checks++;
            if (result !== 9'h000 || select_q !== 1'b0 || result !== e.res) begin
                errors++;
                $display("FAIL reset[%0d]: result=%h select_q=%b, expected 000 0", i, result, select_q);
            end
`ifdef MULTIPLEXER_SWITCH_COUNT_EN
            checks++;
            if (switch_count !== 16'd0) begin
                errors++;
                $display("FAIL reset_count[%0d]: switch_count=%0d, expected 0", i, switch_count);
            end
`endif
        end
    endtask

    task automatic test_select_one();
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, 9'h1FF, 9'h100);
            wait_out();
            checks++;
            if (result !== 9'h1FF || select_q !== 1'b0 || result !== e.res) begin
                errors++;
                $display("FAIL select_one[%0d]: result=%h select_q=%b, expected 1ff 0", i, result, select_q);
            end
        end
    endtask

    task automatic test_switch_two();
        drive(1'b0, 1'b1, 9'h1FF, 9'h100);
        #1;
        checks++;
        if (result !== 9'h1FF || select_q !== 1'b0) begin
            errors++;
            $display("FAIL switch_hold: result=%h select_q=%b before edge, expected 1ff 0", result, select_q);
        end
        wait_out();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                drive(1'b0, 1'b1, 9'h1FF, 9'h100);
                wait_out();
            end
            checks++;
            if (result !== 9'h100 || select_q !== 1'b1 || result !== e.res) begin
                errors++;
                $display("FAIL switch_two[%0d]: result=%h select_q=%b, expected 100 1", i, result, select_q);
            end
        end
    endtask

    task automatic test_toggle();
        logic s;
        for (int p = 0; p < 2; p++) begin
            s = (p == 1);
            for (int i = 0; i < 5; i++) begin
                drive(1'b0, s, 9'h1FF, 9'h100);
                wait_out();
                checks++;
                if (result !== e.res || select_q !== e.sq) begin
                    errors++;
                    $display("FAIL toggle[%0d.%0d]: result=%h select_q=%b, expected %h %b",
                             p, i, result, select_q, e.res, e.sq);
                end
            end
        end
`ifdef MULTIPLEXER_SWITCH_COUNT_EN
        checks++;
        if (switch_count !== 16'd3) begin
            errors++;
            $display("FAIL toggle_count: switch_count=%0d, expected 3", switch_count);
        end
`endif
    endtask

    task automatic test_data_change();
        logic [8:0] r;
        drive(1'b0, 1'b1, 9'h1FF, 9'h0AA);
        wait_out();
        checks++;
        if (result !== 9'h0AA || result !== e.res) begin
            errors++;
            $display("FAIL data_change: result=%h, expected 0aa", result);
        end
        for (int i = 0; i < 4; i++) begin
            r = 9'($urandom);
            drive(1'b0, 1'b1, r, 9'h0AA);
            wait_out();
            checks++;
            if (result !== 9'h0AA || result !== e.res) begin
                errors++;
                $display("FAIL one_ignored[%0d]: result=%h one=%h, expected 0aa", i, result, r);
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 1'b1, 9'h1FF, 9'h100);
        wait_out();
        checks++;
        if (result !== 9'h100 || result !== e.res) begin
            errors++;
            $display("FAIL pre_reset: result=%h, expected 100", result);
        end
        drive(1'b1, 1'b1, 9'h1FF, 9'h100);
        wait_out();
        checks++;
        if (result !== 9'h000 || select_q !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: result=%h select_q=%b, expected 000 0", result, select_q);
        end
`ifdef MULTIPLEXER_SWITCH_COUNT_EN
        checks++;
        if (switch_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid_count: switch_count=%0d, expected 0", switch_count);
        end
`endif
        drive(1'b0, 1'b1, 9'h1FF, 9'h100);
        wait_out();
        checks++;
        if (result !== 9'h100 || select_q !== 1'b1 || result !== e.res) begin
            errors++;
            $display("FAIL after_reset: result=%h select_q=%b, expected 100 1", result, select_q);
        end
`ifdef MULTIPLEXER_SWITCH_COUNT_EN
        checks++;
        if (switch_count !== e.cnt) begin
            errors++;
            $display("FAIL after_reset_count: switch_count=%0d, expected %0d", switch_count, e.cnt);
        end
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            drive(($urandom_range(0, 9) == 0), 1'($urandom), 9'($urandom), 9'($urandom));
            wait_out();
            checks++;
            if (result !== e.res || select_q !== e.sq) begin
                errors++;
                $display("FAIL random[%0d]: result=%h select_q=%b, expected %h %b",
                         i, result, select_q, e.res, e.sq);
            end
`ifdef MULTIPLEXER_SWITCH_COUNT_EN
            checks++;
            if (switch_count !== e.cnt) begin
                errors++;
                $display("FAIL random_count[%0d]: switch_count=%0d, expected %0d", i, switch_count, e.cnt);
            end
`endif
        end
    endtask

`ifdef MULTIPLEXER_SWITCH_COUNT_EN
    task automatic test_saturate();
        drive(1'b1, 1'b0, 9'h000, 9'h000);
        wait_out();
        for (int i = 0; i < 65540; i++) begin
            drive(1'b0, i[0] ? 1'b0 : 1'b1, 9'h000, 9'h000);
            wait_out();
        end
        checks++;
        if (switch_count !== 16'hFFFF || switch_count !== e.cnt) begin
            errors++;
            $display("FAIL saturate: switch_count=%h, expected ffff", switch_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_select_one();
        test_switch_two();
        test_toggle();
        test_data_change();
        test_reset_mid();
        test_random();
`ifdef MULTIPLEXER_SWITCH_COUNT_EN
        test_saturate();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
